fetch: RTL and testbench
========================

# fetch

Instruction fetch stage: reads one 32-bit instruction word per PC from the instruction memory bus and presents it to the decode stage with a valid flag. Consumes the architectural PC published by decode (`o_PC`), holds the fetched word until decode accepts it (`i_EN` high while valid), then refetches at the updated PC. One outstanding bus request at most; no prediction, no prefetch queue.

## Interface
- `NOOP`, 32'h00000013, word substituted on a fault (addi x0,x0,0).
- `TIMEOUT`, 16, cycles allowed for `i_IMEM_ACK` before a fault (used only with the macro).
- `i_CLK`  in  1  clock; reset `i_RSTn` is synchronous, active-low; clock `i_CLK`.
- `i_RSTn`  in  1  synchronous active-low reset.
- `i_PC`  in  32  fetch address from decode `o_PC`.
- `i_EN`  in  1  decode enable; with `o_INSTRUCTION_VALID` high = instruction consumed this edge.
- `i_FLUSH`  in  1  discard held or in-flight instruction, refetch at current `i_PC`.
- `o_IMEM_REQ`  out  1  bus read request.
- `o_IMEM_ADDR`  out  32  word-aligned bus address.
- `i_IMEM_ACK`  in  1  one-cycle data-valid strobe.
- `i_IMEM_DATA`  in  32  read data, sampled when `i_IMEM_ACK`=1.
- `o_INSTRUCTION`  out  32  instruction to decode.
- `o_INSTRUCTION_VALID`  out  1  `o_INSTRUCTION` is valid for `i_PC`.
- `o_FETCH_FAULT`  out  1  one-cycle pulse on misaligned PC or bus timeout.

## Operation
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: entered on reset; next cycle → REQ, latching `o_IMEM_ADDR` = {`i_PC`[31:2],2'b00}.
- REQ: `o_IMEM_REQ`=1, address held stable until ack. On `i_IMEM_ACK`: register `i_IMEM_DATA` into `o_INSTRUCTION`, set valid, → HOLD.
- HOLD: valid=1, `o_INSTRUCTION` stable. On `i_EN`: valid clears at the same edge, → REQ with address latched from `i_PC` on the following cycle (decode updates its PC on that consuming edge).
- Misaligned PC (`i_PC`[1:0]≠0) on entry to REQ: no bus request; `o_INSTRUCTION`=`NOOP`, valid=1, `o_FETCH_FAULT` pulse, → HOLD.
- `i_FLUSH` in HOLD or IDLE: valid clears, → REQ. `i_FLUSH` in REQ before ack: → DRAIN (request deasserts the same edge); DRAIN waits for `i_IMEM_ACK`, discards data, → REQ. `i_FLUSH` with `i_IMEM_ACK` in the same cycle: data discarded, → REQ.
- `i_FLUSH` takes priority over `i_EN` consumption.
- Reset values: `o_IMEM_REQ`=0, `o_IMEM_ADDR`=0, `o_INSTRUCTION`=`NOOP`, `o_INSTRUCTION_VALID`=0, `o_FETCH_FAULT`=0, state IDLE, timeout counter 0. Reset asserted mid-request abandons the transaction; a late ack after reset in IDLE is ignored.

## Timing
- `i_IMEM_ACK` in cycle N → `o_INSTRUCTION_VALID`=1 in cycle N+1.
- Zero-wait bus (ack in the first REQ cycle): 3 cycles per instruction (REQ, HOLD, re-latch).
- Consume at edge E → `o_IMEM_REQ` high with the new address from E+1.
- `o_IMEM_ADDR` changes only on entry to REQ.
- Acks outside REQ/DRAIN are ignored.

## Configuration
- `FETCH_BUS_TIMEOUT_EN` defined: a counter runs in REQ. If `TIMEOUT` cycles pass with no ack, → HOLD with `NOOP`, valid=1, `o_FETCH_FAULT` pulse; the next ack in the following REQ/DRAIN counts normally, and a stale ack is not filtered. The counter clears on every entry to REQ.
- Macro undefined: no counter; REQ waits indefinitely. `o_FETCH_FAULT` comes only from misaligned PCs.

## Test plan
- Reset, `i_PC`=32'h80000000, ack 2 cycles after req with data 32'h00500093 → `o_IMEM_ADDR`=32'h80000000, valid rises the cycle after ack, `o_INSTRUCTION`=32'h00500093.
- Hold `i_EN`=0 for 5 cycles in HOLD → valid and instruction stable, `o_IMEM_REQ`=0; raise `i_EN`, set `i_PC`=32'h80000004 → next req at 32'h80000004.
- `i_PC`=32'h80000002 → no req, `o_INSTRUCTION`=32'h00000013, valid=1, one-cycle `o_FETCH_FAULT`.
- `i_FLUSH` during REQ, ack 3 cycles later with 32'hDEADBEEF → word discarded, valid stays 0, new req issued after ack.
- With `FETCH_BUS_TIMEOUT_EN`, `TIMEOUT`=16, no ack → fault pulse and `NOOP` valid 16 cycles after req rises; without the macro → req stays high for 100 cycles.
- Reset asserted for 1 cycle mid-REQ, then ack → ack ignored, outputs at reset values, fresh req follows IDLE.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding imem read per PC, word held for decode until consumed.
// Optional bus-timeout fault enabled by defining FETCH_BUS_TIMEOUT_EN.
module fetch #(
  parameter logic [31:0] NOOP = 32'h0000_0013
`ifdef FETCH_BUS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic        i_CLK,
  input  logic        i_RSTn,
  input  logic [31:0] i_PC,
  input  logic        i_EN,
  input  logic        i_FLUSH,
  output logic        o_IMEM_REQ,
  output logic [31:0] o_IMEM_ADDR,
  input  logic        i_IMEM_ACK,
  input  logic [31:0] i_IMEM_DATA,
  output logic [31:0] o_INSTRUCTION,
  output logic        o_INSTRUCTION_VALID,
  output logic        o_FETCH_FAULT
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        req_d, valid_d, fault_d;
  logic [31:0] addr_d, instr_d;
  logic        enter_req;

`ifdef FETCH_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d   = state_q;
    req_d     = o_IMEM_REQ;
    addr_d    = o_IMEM_ADDR;
    instr_d   = o_INSTRUCTION;
    valid_d   = o_INSTRUCTION_VALID;
    fault_d   = 1'b0;
    enter_req = 1'b0;
`ifdef FETCH_BUS_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        valid_d   = 1'b0;
        enter_req = 1'b1;
      end
      REQ: begin
        if (i_FLUSH) begin
          valid_d = 1'b0;
          if (i_IMEM_ACK) begin
            enter_req = 1'b1;
          end else begin
            req_d   = 1'b0;
            state_d = DRAIN;
          end
        end else if (i_IMEM_ACK) begin
          req_d   = 1'b0;
          instr_d = i_IMEM_DATA;
          valid_d = 1'b1;
          state_d = HOLD;
        end
`ifdef FETCH_BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          instr_d = NOOP;
          valid_d = 1'b1;
          fault_d = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      HOLD: begin
        // Flush wins over consumption; consumption waits one cycle for decode's new PC.
        if (i_FLUSH) begin
          valid_d   = 1'b0;
          enter_req = 1'b1;
        end else if (i_EN) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (i_IMEM_ACK) begin
          enter_req = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Entry into REQ: a misaligned PC faults straight to HOLD without touching the bus.
    if (enter_req) begin
      if (i_PC[1:0] != 2'b00) begin
        req_d   = 1'b0;
        instr_d = NOOP;
        valid_d = 1'b1;
        fault_d = 1'b1;
        state_d = HOLD;
      end else begin
        req_d   = 1'b1;
        addr_d  = {i_PC[31:2], 2'b00};
        valid_d = 1'b0;
        state_d = REQ;
`ifdef FETCH_BUS_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      state_q             <= IDLE;
      o_IMEM_REQ          <= 1'b0;
      o_IMEM_ADDR         <= '0;
      o_INSTRUCTION       <= NOOP;
      o_INSTRUCTION_VALID <= 1'b0;
      o_FETCH_FAULT       <= 1'b0;
    end else begin
      state_q             <= state_d;
      o_IMEM_REQ          <= req_d;
      o_IMEM_ADDR         <= addr_d;
      o_INSTRUCTION       <= instr_d;
      o_INSTRUCTION_VALID <= valid_d;
      o_FETCH_FAULT       <= fault_d;
    end
  end

`ifdef FETCH_BUS_TIMEOUT_EN
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus a randomized fetch loop.
module tb_fetch;

  localparam logic [31:0] NOOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] data = '0;
  logic        o_IMEM_REQ;
  logic [31:0] o_IMEM_ADDR;
  logic [31:0] o_INSTRUCTION;
  logic        o_INSTRUCTION_VALID;
  logic        o_FETCH_FAULT;

  int checks = 0;
  int errors = 0;

  fetch dut (
    .i_CLK              (clk),
    .i_RSTn             (rst_n),
    .i_PC               (pc),
    .i_EN               (en),
    .i_FLUSH            (flush),
    .o_IMEM_REQ         (o_IMEM_REQ),
    .o_IMEM_ADDR        (o_IMEM_ADDR),
    .i_IMEM_ACK         (ack),
    .i_IMEM_DATA        (data),
    .o_INSTRUCTION      (o_INSTRUCTION),
    .o_INSTRUCTION_VALID(o_INSTRUCTION_VALID),
    .o_FETCH_FAULT      (o_FETCH_FAULT)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a3c_9617;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; pc = 32'h8000_0000; en = 1'b0; flush = 1'b0; ack = 1'b0; data = '0;
    tick; tick;
    checks++; if (o_IMEM_REQ !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h exp=0", o_IMEM_REQ); end
    checks++; if (o_IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", o_IMEM_ADDR); end
    checks++; if (o_INSTRUCTION !== NOOP_W) begin errors++; $display("FAIL rst_instr got=%h exp=%h", o_INSTRUCTION, NOOP_W); end
    checks++; if (o_INSTRUCTION_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", o_INSTRUCTION_VALID); end
    checks++; if (o_FETCH_FAULT !== 1'b0) begin errors++; $display("FAIL rst_fault got=%0h exp=0", o_FETCH_FAULT); end
  endtask

  task automatic test_first_fetch;
    rst_n = 1'b1;
    tick;
    checks++; if (o_IMEM_REQ !== 1'b1) begin errors++; $display("FAIL ff_req got=%0h exp=1", o_IMEM_REQ); end
    checks++; if (o_IMEM_ADDR !== 32'h8000_0000) begin errors++; $display("FAIL ff_addr got=%h exp=80000000", o_IMEM_ADDR); end
    tick; tick;
    ack = 1'b1; data = 32'h0050_0093;
    checks++; if (o_INSTRUCTION_VALID !== 1'b0 || o_IMEM_REQ !== 1'b1) begin errors++; $display("FAIL ff_wait got valid=%0h req=%0h exp valid=0 req=1", o_INSTRUCTION_VALID, o_IMEM_REQ); end
    tick;
    ack = 1'b0;
    checks++; if (o_INSTRUCTION_VALID !== 1'b1) begin errors++; $display("FAIL ff_valid got=%0h exp=1", o_INSTRUCTION_VALID); end
    checks++; if (o_INSTRUCTION !== 32'h0050_0093) begin errors++; $display("FAIL ff_instr got=%h exp=00500093", o_INSTRUCTION); end
    checks++; if (o_IMEM_REQ !== 1'b0) begin errors++; $display("FAIL ff_req_drop got=%0h exp=0", o_IMEM_REQ); end
  endtask

  task automatic test_hold;
    repeat (5) begin
      tick;
      checks++;
      if (o_INSTRUCTION_VALID !== 1'b1 || o_INSTRUCTION !== 32'h0050_0093 || o_IMEM_REQ !== 1'b0) begin
        errors++; $display("FAIL hold_stable got valid=%0h instr=%h req=%0h exp 1/00500093/0", o_INSTRUCTION_VALID, o_INSTRUCTION, o_IMEM_REQ);
      end
    end
    en = 1'b1; pc = 32'h8000_0004;
    tick;
    en = 1'b0;
    checks++; if (o_INSTRUCTION_VALID !== 1'b0 || o_IMEM_REQ !== 1'b0) begin errors++; $display("FAIL hold_consume got valid=%0h req=%0h exp 0/0", o_INSTRUCTION_VALID, o_IMEM_REQ); end
    tick;
    checks++; if (o_IMEM_REQ !== 1'b1 || o_IMEM_ADDR !== 32'h8000_0004) begin errors++; $display("FAIL hold_next_req got req=%0h addr=%h exp 1/80000004", o_IMEM_REQ, o_IMEM_ADDR); end
    ack = 1'b1; data = 32'h00a0_0113;
    tick;
    ack = 1'b0;
    checks++; if (o_INSTRUCTION_VALID !== 1'b1 || o_INSTRUCTION !== 32'h00a0_0113) begin errors++; $display("FAIL hold_zero_wait got valid=%0h instr=%h exp 1/00a00113", o_INSTRUCTION_VALID, o_INSTRUCTION); end
  endtask

  task automatic test_misaligned;
    en = 1'b1; pc = 32'h8000_0002;
    tick;
    en = 1'b0;
    checks++; if (o_INSTRUCTION_VALID !== 1'b0) begin errors++; $display("FAIL mis_consume got=%0h exp=0", o_INSTRUCTION_VALID); end
    tick;
    checks++; if (o_IMEM_REQ !== 1'b0) begin errors++; $display("FAIL mis_req got=%0h exp=0", o_IMEM_REQ); end
    checks++; if (o_INSTRUCTION_VALID !== 1'b1 || o_INSTRUCTION !== NOOP_W) begin errors++; $display("FAIL mis_noop got valid=%0h instr=%h exp 1/%h", o_INSTRUCTION_VALID, o_INSTRUCTION, NOOP_W); end
    checks++; if (o_FETCH_FAULT !== 1'b1) begin errors++; $display("FAIL mis_fault got=%0h exp=1", o_FETCH_FAULT); end
    tick;
    checks++; if (o_FETCH_FAULT !== 1'b0 || o_INSTRUCTION_VALID !== 1'b1 || o_IMEM_REQ !== 1'b0) begin errors++; $display("FAIL mis_pulse got fault=%0h valid=%0h req=%0h exp 0/1/0", o_FETCH_FAULT, o_INSTRUCTION_VALID, o_IMEM_REQ); end
  endtask

  task automatic test_flush;
    en = 1'b1; pc = 32'h8000_0008;
    tick;
    en = 1'b0;
    tick;
    checks++; if (o_IMEM_REQ !== 1'b1 || o_IMEM_ADDR !== 32'h8000_0008) begin errors++; $display("FAIL fl_req got req=%0h addr=%h exp 1/80000008", o_IMEM_REQ, o_IMEM_ADDR); end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    checks++; if (o_IMEM_REQ !== 1'b0 || o_INSTRUCTION_VALID !== 1'b0) begin errors++; $display("FAIL fl_drain got req=%0h valid=%0h exp 0/0", o_IMEM_REQ, o_INSTRUCTION_VALID); end
    tick; tick;
    checks++; if (o_IMEM_REQ !== 1'b0 || o_INSTRUCTION_VALID !== 1'b0) begin errors++; $display("FAIL fl_drain_wait got req=%0h valid=%0h exp 0/0", o_IMEM_REQ, o_INSTRUCTION_VALID); end
    ack = 1'b1; data = 32'hDEAD_BEEF;
    tick;
    ack = 1'b0;
    checks++; if (o_IMEM_REQ !== 1'b1 || o_IMEM_ADDR !== 32'h8000_0008 || o_INSTRUCTION_VALID !== 1'b0) begin errors++; $display("FAIL fl_rereq got req=%0h addr=%h valid=%0h exp 1/80000008/0", o_IMEM_REQ, o_IMEM_ADDR, o_INSTRUCTION_VALID); end
    checks++; if (o_INSTRUCTION === 32'hDEAD_BEEF) begin errors++; $display("FAIL fl_discard got instr=%h exp anything but deadbeef", o_INSTRUCTION); end
    pc = 32'h8000_000c; flush = 1'b1; ack = 1'b1; data = 32'h1111_1111;
    tick;
    flush = 1'b0; ack = 1'b0;
    checks++; if (o_IMEM_REQ !== 1'b1 || o_IMEM_ADDR !== 32'h8000_000c || o_INSTRUCTION_VALID !== 1'b0) begin errors++; $display("FAIL fl_with_ack got req=%0h addr=%h valid=%0h exp 1/8000000c/0", o_IMEM_REQ, o_IMEM_ADDR, o_INSTRUCTION_VALID); end
    ack = 1'b1; data = 32'h2222_2222;
    tick;
    ack = 1'b0;
    checks++; if (o_INSTRUCTION_VALID !== 1'b1 || o_INSTRUCTION !== 32'h2222_2222) begin errors++; $display("FAIL fl_refetch got valid=%0h instr=%h exp 1/22222222", o_INSTRUCTION_VALID, o_INSTRUCTION); end
    pc = 32'h8000_0010; flush = 1'b1; en = 1'b1;
    tick;
    flush = 1'b0; en = 1'b0;
    checks++; if (o_IMEM_REQ !== 1'b1 || o_IMEM_ADDR !== 32'h8000_0010 || o_INSTRUCTION_VALID !== 1'b0) begin errors++; $display("FAIL fl_prio got req=%0h addr=%h valid=%0h exp 1/80000010/0", o_IMEM_REQ, o_IMEM_ADDR, o_INSTRUCTION_VALID); end
    ack = 1'b1; data = 32'h3333_3333;
    tick;
    ack = 1'b0;
    checks++; if (o_INSTRUCTION_VALID !== 1'b1 || o_INSTRUCTION !== 32'h3333_3333) begin errors++; $display("FAIL fl_hold_fetch got valid=%0h instr=%h exp 1/33333333", o_INSTRUCTION_VALID, o_INSTRUCTION); end
  endtask

  task automatic test_timeout;
    int bad;
    bad = 0;
    en = 1'b1; pc = 32'h8000_0014;
    tick;
    en = 1'b0;
    tick;
    checks++; if (o_IMEM_REQ !== 1'b1) begin errors++; $display("FAIL to_req got=%0h exp=1", o_IMEM_REQ); end
`ifdef FETCH_BUS_TIMEOUT_EN
    repeat (15) begin
      tick;
      if (o_IMEM_REQ !== 1'b1 || o_INSTRUCTION_VALID !== 1'b0 || o_FETCH_FAULT !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL to_early got %0d bad cycles exp 0", bad); end
    tick;
    checks++; if (o_FETCH_FAULT !== 1'b1 || o_INSTRUCTION_VALID !== 1'b1 || o_INSTRUCTION !== NOOP_W || o_IMEM_REQ !== 1'b0) begin errors++; $display("FAIL to_fault got fault=%0h valid=%0h instr=%h req=%0h exp 1/1/%h/0", o_FETCH_FAULT, o_INSTRUCTION_VALID, o_INSTRUCTION, o_IMEM_REQ, NOOP_W); end
    tick;
    checks++; if (o_FETCH_FAULT !== 1'b0) begin errors++; $display("FAIL to_pulse got=%0h exp=0", o_FETCH_FAULT); end
`else
    repeat (100) begin
      tick;
      if (o_IMEM_REQ !== 1'b1 || o_INSTRUCTION_VALID !== 1'b0 || o_FETCH_FAULT !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL to_wait got %0d bad cycles exp 0", bad); end
    ack = 1'b1; data = 32'h4444_4444;
    tick;
    ack = 1'b0;
    checks++; if (o_INSTRUCTION_VALID !== 1'b1 || o_INSTRUCTION !== 32'h4444_4444) begin errors++; $display("FAIL to_late_ack got valid=%0h instr=%h exp 1/44444444", o_INSTRUCTION_VALID, o_INSTRUCTION); end
`endif
  endtask

  task automatic test_reset_mid_req;
    en = 1'b1; pc = 32'h8000_0018;
    tick;
    en = 1'b0;
    tick;
    checks++; if (o_IMEM_REQ !== 1'b1 || o_IMEM_ADDR !== 32'h8000_0018) begin errors++; $display("FAIL rm_req got req=%0h addr=%h exp 1/80000018", o_IMEM_REQ, o_IMEM_ADDR); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++; if (o_IMEM_REQ !== 1'b0 || o_IMEM_ADDR !== 32'h0 || o_INSTRUCTION !== NOOP_W || o_INSTRUCTION_VALID !== 1'b0 || o_FETCH_FAULT !== 1'b0) begin
      errors++; $display("FAIL rm_reset got req=%0h addr=%h instr=%h valid=%0h fault=%0h exp 0/0/%h/0/0", o_IMEM_REQ, o_IMEM_ADDR, o_INSTRUCTION, o_INSTRUCTION_VALID, o_FETCH_FAULT, NOOP_W);
    end
    ack = 1'b1; data = 32'hCAFE_F00D;
    tick;
    ack = 1'b0;
    checks++; if (o_IMEM_REQ !== 1'b1 || o_IMEM_ADDR !== 32'h8000_0018 || o_INSTRUCTION_VALID !== 1'b0 || o_INSTRUCTION !== NOOP_W) begin
      errors++; $display("FAIL rm_stale_ack got req=%0h addr=%h valid=%0h instr=%h exp 1/80000018/0/%h", o_IMEM_REQ, o_IMEM_ADDR, o_INSTRUCTION_VALID, o_INSTRUCTION, NOOP_W);
    end
    ack = 1'b1; data = word_at(o_IMEM_ADDR);
    tick;
    ack = 1'b0;
    checks++; if (o_INSTRUCTION_VALID !== 1'b1 || o_INSTRUCTION !== word_at(32'h8000_0018)) begin errors++; $display("FAIL rm_fetch got valid=%0h instr=%h exp 1/%h", o_INSTRUCTION_VALID, o_INSTRUCTION, word_at(32'h8000_0018)); end
    en = 1'b1;
    tick;
    en = 1'b0;
  endtask

  // Randomized PCs, bus latencies, flushes, hold times and stray acks against the fetch rules.
  task automatic test_back_to_back;
    logic [31:0] a, aligned, exp_instr;
    logic        mis;
    int          d;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      mis = ($urandom_range(3) == 0);
      a[1:0] = mis ? 2'($urandom_range(3, 1)) : 2'b00;
      aligned = {a[31:2], 2'b00};
      pc = a;
      tick;
      if (mis) begin
        exp_instr = NOOP_W;
        checks++; if (o_IMEM_REQ !== 1'b0 || o_INSTRUCTION_VALID !== 1'b1 || o_INSTRUCTION !== NOOP_W || o_FETCH_FAULT !== 1'b1) begin
          errors++; $display("FAIL rnd_mis[%0d] got req=%0h valid=%0h instr=%h fault=%0h exp 0/1/%h/1", i, o_IMEM_REQ, o_INSTRUCTION_VALID, o_INSTRUCTION, o_FETCH_FAULT, NOOP_W);
        end
      end else begin
        exp_instr = word_at(aligned);
        checks++; if (o_IMEM_REQ !== 1'b1 || o_IMEM_ADDR !== aligned) begin errors++; $display("FAIL rnd_req[%0d] got req=%0h addr=%h exp 1/%h", i, o_IMEM_REQ, o_IMEM_ADDR, aligned); end
        if ($urandom_range(4) == 0) begin
          flush = 1'b1;
          tick;
          flush = 1'b0;
          checks++; if (o_IMEM_REQ !== 1'b0) begin errors++; $display("FAIL rnd_drain[%0d] got req=%0h exp 0", i, o_IMEM_REQ); end
          repeat ($urandom_range(2)) tick;
          ack = 1'b1; data = $urandom;
          tick;
          ack = 1'b0;
          checks++; if (o_IMEM_REQ !== 1'b1 || o_IMEM_ADDR !== aligned || o_INSTRUCTION_VALID !== 1'b0) begin errors++; $display("FAIL rnd_rereq[%0d] got req=%0h addr=%h valid=%0h exp 1/%h/0", i, o_IMEM_REQ, o_IMEM_ADDR, o_INSTRUCTION_VALID, aligned); end
        end
        d = $urandom_range(4);
        repeat (d) begin
          tick;
          checks++; if (o_IMEM_REQ !== 1'b1 || o_INSTRUCTION_VALID !== 1'b0) begin errors++; $display("FAIL rnd_wait[%0d] got req=%0h valid=%0h exp 1/0", i, o_IMEM_REQ, o_INSTRUCTION_VALID); end
        end
        ack = 1'b1; data = word_at(o_IMEM_ADDR);
        tick;
        ack = 1'b0;
        checks++; if (o_INSTRUCTION_VALID !== 1'b1 || o_INSTRUCTION !== exp_instr || o_IMEM_REQ !== 1'b0) begin
          errors++; $display("FAIL rnd_data[%0d] got valid=%0h instr=%h req=%0h exp 1/%h/0", i, o_INSTRUCTION_VALID, o_INSTRUCTION, o_IMEM_REQ, exp_instr);
        end
      end
      repeat ($urandom_range(3)) begin
        ack = 1'($urandom_range(1)); data = $urandom;
        tick;
        ack = 1'b0;
        checks++; if (o_INSTRUCTION_VALID !== 1'b1 || o_INSTRUCTION !== exp_instr || o_IMEM_REQ !== 1'b0 || o_FETCH_FAULT !== 1'b0) begin
          errors++; $display("FAIL rnd_hold[%0d] got valid=%0h instr=%h req=%0h fault=%0h exp 1/%h/0/0", i, o_INSTRUCTION_VALID, o_INSTRUCTION, o_IMEM_REQ, o_FETCH_FAULT, exp_instr);
        end
      end
      en = 1'b1;
      tick;
      en = 1'b0;
      checks++; if (o_INSTRUCTION_VALID !== 1'b0 || o_IMEM_REQ !== 1'b0) begin errors++; $display("FAIL rnd_consume[%0d] got valid=%0h req=%0h exp 0/0", i, o_INSTRUCTION_VALID, o_IMEM_REQ); end
    end
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_hold;
    test_misaligned;
    test_flush;
    test_timeout;
    test_reset_mid_req;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
